// File: rtl/dmem_arb_pkg.sv
// Shared types and data-segment constants for the data-memory arbiter,
// the processor top and the memory benches.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef logic port_idx_t;

  localparam logic [31:0] DMEM_DATA_BASE = 32'h1000_0000;
  localparam logic [31:0] DMEM_DATA_SIZE = 32'h0000_1000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker. The pointer names the favoured port and
// moves to the other port after every accepted grant.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  port_idx_t ptr_q, ptr_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (advance) begin
      if (grant[0]) begin
        ptr_d = 1'b1;
      end else if (grant[1]) begin
        ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (IDLE/ACCESS/RESP).
// Optional address range/alignment checking is enabled by DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(DMEM_DATA_BASE),
  parameter logic [ADDR_W-1:0] DATA_SIZE = ADDR_W'(DMEM_DATA_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  port_idx_t         owner_q, owner_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rd_val;
  logic [1:0]        arb_req, grant;
  logic              advance, acc_err, range_bad;
  port_idx_t         sel;
  logic [ADDR_W-1:0] req_addr;

  // Grants are only ever issued from IDLE.
  assign arb_req  = {p1_req, p0_req} & {2{state_q == ST_IDLE}};
  assign advance  = |grant;
  assign sel      = grant[1];
  assign req_addr = sel ? p1_addr : p0_addr;
  assign p0_gnt   = grant[0];
  assign p1_gnt   = grant[1];
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .advance(advance),
    .grant  (grant)
  );

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] SEG_LO = {1'b0, DATA_BASE};
  localparam logic [ADDR_W:0] SEG_HI = SEG_LO + {1'b0, DATA_SIZE};

  logic err_q, err_d;

  assign range_bad = ({1'b0, req_addr} < SEG_LO) || ({1'b0, req_addr} >= SEG_HI) ||
                     (req_addr[1:0] != 2'b00);
  assign acc_err   = err_q;
  assign err_d     = (state_q == ST_IDLE && advance) ? range_bad : err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{DATA_BASE, DATA_SIZE, req_addr[1:0]};
  assign range_bad  = 1'b0;
  assign acc_err    = 1'b0;
`endif

  assign rd_val = (we_q || acc_err) ? '0 : mem_dout;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mem_cs   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    p0_done  = 1'b0;
    p1_done  = 1'b0;
    p0_err   = 1'b0;
    p1_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (advance) begin
          we_d    = sel ? p1_we : p0_we;
          addr_d  = req_addr;
          wdata_d = sel ? p1_wdata : p0_wdata;
          owner_d = sel;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A flagged access keeps the memory completely untouched.
        if (!acc_err) begin
          mem_cs   = 1'b1;
          mem_oe   = ~we_q;
          mem_we   = we_q;
          mem_addr = addr_q;
          mem_din  = we_q ? wdata_q : '0;
        end
        if (owner_q) begin
          rdata1_d = rd_val;
        end else begin
          rdata0_d = rd_val;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        p0_done = ~owner_q;
        p1_done = owner_q;
        p0_err  = ~owner_q & acc_err;
        p1_err  = owner_q & acc_err;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      owner_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      owner_q  <= owner_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule
